// File: rtl/memory_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and
// data access, alternating grants under contention and producing pipeline stalls.
module memory_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  output logic [DATA_W-1:0] IF_Data,
  output logic              IF_Ready,
  input  logic              D_Read,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_Write_Data,
  output logic [DATA_W-1:0] D_Read_Data,
  output logic              D_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Write_Data,
  output logic              Mem_Read,
  output logic              Mem_Write,
  input  logic [DATA_W-1:0] Mem_Read_Data,
  output logic              Stall_Fetch,
  output logic              Stall_Mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_d_q, last_d_d;
  logic                is_wr_q, is_wr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                d_req_s;
  logic                strobe_s;

  assign d_req_s  = D_Read | D_Write;
  assign strobe_s = mem_read_q | mem_write_q;

  // Next-state, grant and capture logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    is_wr_d     = is_wr_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_s && (!IF_Req || !last_d_q)) begin
          state_d     = WAIT_D;
          mem_addr_d  = D_Addr;
          mem_wdata_d = D_Write_Data;
          mem_write_d = D_Write;
          mem_read_d  = ~D_Write;
          is_wr_d     = D_Write;
          cnt_d       = LAT;
          last_d_d    = 1'b1;
        end else if (IF_Req) begin
          state_d    = WAIT_I;
          mem_addr_d = IF_Addr;
          mem_read_d = 1'b1;
          is_wr_d    = 1'b0;
          cnt_d      = LAT;
          last_d_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_I, WAIT_D: begin
        // The strobe cycle itself does not count toward the memory latency
        if (strobe_s) begin
          cnt_d = cnt_q;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = DONE;
          if (state_q == WAIT_I) begin
            if_data_d  = Mem_Read_Data;
            if_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            if (!is_wr_q) begin
              d_rdata_d = Mem_Read_Data;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_d_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      is_wr_q     <= is_wr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign Mem_Read       = mem_read_q;
  assign Mem_Write      = mem_write_q;
  assign Mem_Addr       = mem_addr_q;
  assign Mem_Write_Data = mem_wdata_q;
  assign IF_Data        = if_data_q;
  assign D_Read_Data    = d_rdata_q;
  assign IF_Ready       = if_ready_q;
  assign D_Ready        = d_ready_q;
  assign Stall_Fetch    = IF_Req & ~if_ready_q;
  assign Stall_Mem      = d_req_s & ~d_ready_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance at latency 2, one at latency 1,
// each with a small memory model that drives valid read data only in the expected cycle.
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  // latency-2 instance
  logic        if_req = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
  logic [31:0] if_data, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_read, mem_write, stall_f, stall_m;
  logic [31:0] mem_val = 32'd0;
  logic [15:0] pipe0 = 16'd0;

  // latency-1 instance
  logic        d_read1 = 1'b0;
  logic [31:0] d_addr1 = 32'd0;
  logic [31:0] if_data1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready1, d_ready1, mem_read1, mem_write1, stall_f1, stall_m1;
  logic [31:0] mem_val1 = 32'd0;
  logic [15:0] pipe1 = 16'd0;

  logic [31:0] exp_addr [4];

  always #5 clk = ~clk;

  // memory models: data valid MEM_LATENCY cycles after the strobe cycle, garbage otherwise
  always @(posedge clk) begin
    pipe0 <= {pipe0[14:0], mem_read | mem_write};
    pipe1 <= {pipe1[14:0], mem_read1 | mem_write1};
  end
  assign mem_rdata  = pipe0[1] ? mem_val  : 32'hBAD0BAD0;
  assign mem_rdata1 = pipe1[0] ? mem_val1 : 32'hBAD0BAD0;

  memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .IF_Req(if_req), .IF_Addr(if_addr), .IF_Data(if_data), .IF_Ready(if_ready),
    .D_Read(d_read), .D_Write(d_write), .D_Addr(d_addr), .D_Write_Data(d_wdata),
    .D_Read_Data(d_rdata), .D_Ready(d_ready),
    .Mem_Addr(mem_addr), .Mem_Write_Data(mem_wdata), .Mem_Read(mem_read),
    .Mem_Write(mem_write), .Mem_Read_Data(mem_rdata),
    .Stall_Fetch(stall_f), .Stall_Mem(stall_m)
  );

  memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .IF_Req(1'b0), .IF_Addr(32'd0), .IF_Data(if_data1), .IF_Ready(if_ready1),
    .D_Read(d_read1), .D_Write(1'b0), .D_Addr(d_addr1), .D_Write_Data(32'd0),
    .D_Read_Data(d_rdata1), .D_Ready(d_ready1),
    .Mem_Addr(mem_addr1), .Mem_Write_Data(mem_wdata1), .Mem_Read(mem_read1),
    .Mem_Write(mem_write1), .Mem_Read_Data(mem_rdata1),
    .Stall_Fetch(stall_f1), .Stall_Mem(stall_m1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a pending load
    d_read = 1'b1; d_addr = 32'h20; mem_val = 32'h11111111;
    tick();
    chk("midrst_strobe", {31'd0, mem_read}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    d_read = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_ready", {31'd0, d_ready}, 32'd0);
    end
    chk("midrst_d_rdata", d_rdata, 32'd0);

    // lone fetch (cycle r)
    if_req = 1'b1; if_addr = 32'h10; mem_val = 32'h8C220004;
    #1;
    chk("fetch_stall_r", {31'd0, stall_f}, 32'd1);
    tick();
    chk("fetch_strobe", {30'd0, mem_read, mem_write}, 32'd2);
    chk("fetch_addr", mem_addr, 32'h10);
    chk("fetch_stall_r1", {31'd0, stall_f}, 32'd1);
    tick();
    chk("fetch_strobe_off", {31'd0, mem_read}, 32'd0);
    tick();
    chk("fetch_ready_early", {31'd0, if_ready}, 32'd0);
    chk("fetch_stall_r3", {31'd0, stall_f}, 32'd1);
    tick();
    chk("fetch_ready", {30'd0, if_ready, d_ready}, 32'd2);
    chk("fetch_data", if_data, 32'h8C220004);
    chk("fetch_stall_r4", {31'd0, stall_f}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("fetch_ready_pulse", {31'd0, if_ready}, 32'd0);
    chk("fetch_data_hold", if_data, 32'h8C220004);

    // lone store
    d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_val = 32'h55555555;
    tick();
    chk("store_strobe", {30'd0, mem_read, mem_write}, 32'd1);
    chk("store_addr", mem_addr, 32'h40);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("store_strobe_off", {31'd0, mem_write}, 32'd0);
    tick();
    chk("store_stall", {31'd0, stall_m}, 32'd1);
    tick();
    chk("store_ready", {30'd0, if_ready, d_ready}, 32'd1);
    chk("store_d_rdata", d_rdata, 32'd0);
    chk("store_stall_rdy", {31'd0, stall_m}, 32'd0);
    d_write = 1'b0;
    tick();

    // simultaneous fetch and load from reset: data first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h100; d_read = 1'b1; d_addr = 32'h200; mem_val = 32'hA5A5A5A5;
    tick();
    chk("both_first_addr", mem_addr, 32'h200);
    chk("both_first_strobe", {31'd0, mem_read}, 32'd1);
    tick(); tick(); tick();
    chk("both_d_ready", {30'd0, if_ready, d_ready}, 32'd1);
    chk("both_d_data", d_rdata, 32'hA5A5A5A5);
    chk("both_stalls", {30'd0, stall_f, stall_m}, 32'd2);
    d_read = 1'b0;
    tick();
    mem_val = 32'h5A5A5A5A;
    chk("both_gap", {31'd0, mem_read}, 32'd0);
    tick();
    chk("both_i_strobe", {31'd0, mem_read}, 32'd1);
    chk("both_i_addr", mem_addr, 32'h100);
    tick(); tick();
    chk("both_i_early", {31'd0, if_ready}, 32'd0);
    tick();
    chk("both_i_ready", {30'd0, if_ready, d_ready}, 32'd2);
    chk("both_i_data", if_data, 32'h5A5A5A5A);
    chk("both_d_hold", d_rdata, 32'hA5A5A5A5);
    if_req = 1'b0;
    tick();

    // continuous contention: grants alternate D, I, D, I
    exp_addr[0] = 32'h300; exp_addr[1] = 32'h304;
    exp_addr[2] = 32'h300; exp_addr[3] = 32'h304;
    if_req = 1'b1; if_addr = 32'h304; d_read = 1'b1; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_strobe", {31'd0, mem_read}, 32'd1);
      chk("alt_addr", mem_addr, exp_addr[k]);
      tick(); tick(); tick(); tick();
    end
    if_req = 1'b0; d_read = 1'b0;
    tick();

    // latency-1 lone load
    d_read1 = 1'b1; d_addr1 = 32'h80; mem_val1 = 32'h12345678;
    tick();
    chk("lat1_strobe", {31'd0, mem_read1}, 32'd1);
    chk("lat1_addr", mem_addr1, 32'h80);
    tick();
    chk("lat1_early", {31'd0, d_ready1}, 32'd0);
    tick();
    chk("lat1_ready", {31'd0, d_ready1}, 32'd1);
    chk("lat1_data", d_rdata1, 32'h12345678);
    d_read1 = 1'b0;
    tick();
    chk("lat1_pulse", {31'd0, d_ready1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
